// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the rPLL lock sequencer and its synchronizer.
package pll_seq_pkg;

    localparam int RETRY_W     = 4;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } pll_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic multi-flop synchronizer (depth from pll_seq_pkg), synchronously reset to 0.
module sync_2ff
    import pll_seq_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Gowin rPLL bring-up sequencer: reset hold, lock wait, stability check, retry/fail.
// Optional lock-loss glitch filter in RUN is enabled by defining PLL_SEQ_GLITCH_FILTER_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 2700000,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 22,
    parameter int GLITCH_CYCLES       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               restart_req,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               ready,
    output logic               error,
    output logic [RETRY_W-1:0] retry_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   tcnt, tcnt_n;
    logic [RETRY_W-1:0] retry_n;
    logic               lock_s;
    logic               failure;

`ifdef PLL_SEQ_GLITCH_FILTER_EN
    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
    logic [GW-1:0] gcnt, gcnt_n;
`else
    // Filter length only matters when the glitch filter is built.
    localparam int unused_glitch_cycles = GLITCH_CYCLES;
`endif

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        retry_n = retry_count;
        failure = 1'b0;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
        gcnt_n  = gcnt;
`endif
        case (state)
            S_RESET: begin
                if (cnt == HOLD_LAST) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                    tcnt_n  = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (tcnt == TIMEOUT_LAST) begin
                    failure = 1'b1;
                end else begin
                    tcnt_n = tcnt + CNT_W'(1);
                    if (lock_s) begin
                        state_n = S_STABLE;
                        cnt_n   = '0;
                    end
                end
            end
            S_STABLE: begin
                // Reaching the stability threshold takes priority over a coincident timeout.
                if (lock_s && cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    retry_n = '0;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
                    gcnt_n  = '0;
`endif
                end else if (tcnt == TIMEOUT_LAST) begin
                    failure = 1'b1;
                end else begin
                    tcnt_n = tcnt + CNT_W'(1);
                    if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
`ifdef PLL_SEQ_GLITCH_FILTER_EN
                if (lock_s) begin
                    gcnt_n = '0;
                end else if (gcnt == GLITCH_LAST) begin
                    failure = 1'b1;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                end
`else
                if (!lock_s) begin
                    failure = 1'b1;
                end
`endif
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_RESET;
                cnt_n   = '0;
            end
        endcase

        if (failure) begin
            if (32'(retry_count) < MAX_RETRIES) begin
                retry_n = (retry_count == '1) ? retry_count : retry_count + RETRY_W'(1);
                state_n = S_RESET;
                cnt_n   = '0;
            end else begin
                state_n = S_FAIL;
            end
        end

        // A restart request overrides everything, including a failure in the same cycle.
        if (restart_req) begin
            state_n = S_RESET;
            cnt_n   = '0;
            tcnt_n  = '0;
            retry_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            cnt         <= '0;
            tcnt        <= '0;
            retry_count <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            error       <= 1'b0;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
            gcnt        <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tcnt        <= tcnt_n;
            retry_count <= retry_n;
            pll_reset   <= (state_n == S_RESET) || (state_n == S_FAIL);
            sys_reset   <= (state_n != S_RUN);
            ready       <= (state_n == S_RUN);
            error       <= (state_n == S_FAIL);
`ifdef PLL_SEQ_GLITCH_FILTER_EN
            gcnt        <= gcnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios plus a randomized PLL model.
module tb_pll_lock_sequencer;

    localparam int HOLD    = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 50;
    localparam int MAXR    = 2;
    localparam int CW      = 8;
    localparam int GLITCH  = 4;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
    localparam int LOSS = GLITCH;
`else
    localparam int LOSS = 1;
`endif

    localparam int M_HOLD = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_DEAD = 4;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       restart_req;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       error;
    logic [3:0] retry_count;

    int vec_count;
    int err_count;

    int m_mode, m_hold, m_att, m_stab, m_low, m_fails;
    bit m_sync[$];

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAXR),
        .CNT_W               (CW),
        .GLITCH_CYCLES       (GLITCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .restart_req (restart_req),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .error       (error),
        .retry_count (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Attempt-level view of the sequencer: elapsed times per phase and the failure tally.
    function automatic void model_fail();
        if (m_fails < MAXR) begin
            m_fails = (m_fails < 15) ? m_fails + 1 : 15;
            m_mode  = M_HOLD;
            m_hold  = 0;
        end else begin
            m_mode = M_DEAD;
        end
    endfunction

    function automatic void model_step(input bit rst, input bit lock, input bit req);
        bit ls;
        if (rst) begin
            m_mode  = M_HOLD;
            m_hold  = 0;
            m_fails = 0;
            m_sync  = {1'b0, 1'b0};
            return;
        end
        ls = m_sync[0];
        void'(m_sync.pop_front());
        m_sync.push_back(lock);
        if (req) begin
            m_mode  = M_HOLD;
            m_hold  = 0;
            m_fails = 0;
            return;
        end
        case (m_mode)
            M_HOLD: begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_mode = M_WAIT;
                    m_att  = 0;
                end
            end
            M_WAIT: begin
                m_att++;
                if (m_att == TIMEOUT) model_fail();
                else if (ls) begin
                    m_mode = M_STAB;
                    m_stab = 0;
                end
            end
            M_STAB: begin
                m_att++;
                m_stab++;
                if (m_stab == STABLE && ls) begin
                    m_mode  = M_RUN;
                    m_low   = 0;
                    m_fails = 0;
                end else if (m_att == TIMEOUT) model_fail();
                else if (!ls) m_mode = M_WAIT;
            end
            M_RUN: begin
                if (ls) m_low = 0;
                else begin
                    m_low++;
                    if (m_low >= LOSS) model_fail();
                end
            end
            default: m_mode = M_DEAD;
        endcase
    endfunction

    task automatic applyStimulus(input bit rst, input bit lock, input bit req);
        @(negedge clk);
        reset       = rst;
        pll_lock    = lock;
        restart_req = req;
        @(posedge clk);
        model_step(rst, lock, req);
        #1;
        checkOutput("pll_reset",   {7'd0, pll_reset}, {7'd0, (m_mode == M_HOLD || m_mode == M_DEAD)});
        checkOutput("sys_reset",   {7'd0, sys_reset}, {7'd0, (m_mode != M_RUN)});
        checkOutput("ready",       {7'd0, ready},     {7'd0, (m_mode == M_RUN)});
        checkOutput("error",       {7'd0, error},     {7'd0, (m_mode == M_DEAD)});
        checkOutput("retry_count", {4'd0, retry_count}, 8'(m_fails));
    endtask

    initial begin
        int guard;
        int delay;
        int burst;
        bit lk;
        bit rq;
        bit rs;

        vec_count   = 0;
        err_count   = 0;
        reset       = 1'b1;
        pll_lock    = 1'b0;
        restart_req = 1'b0;
        m_sync      = {1'b0, 1'b0};
        m_mode = M_HOLD; m_hold = 0; m_att = 0; m_stab = 0; m_low = 0; m_fails = 0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] clean lock");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("clean_ready", {7'd0, ready}, 8'd1);

        $display("[TB] lock never rises");
        repeat (3 * (HOLD + TIMEOUT) + 220) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fail_error", {7'd0, error}, 8'd1);
        checkOutput("fail_pll_reset", {7'd0, pll_reset}, 8'd1);
        checkOutput("fail_retry", {4'd0, retry_count}, 8'(MAXR));

        $display("[TB] restart from fail");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("restart_error", {7'd0, error}, 8'd0);
        checkOutput("restart_retry", {4'd0, retry_count}, 8'd0);

        $display("[TB] glitch during stable");
        guard = 0;
        while (!(m_mode == M_STAB && m_stab == 5) && guard < 100) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 100) checkOutput("wait_stable5", 8'd0, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("glitch_ready", {7'd0, ready}, 8'd1);

        $display("[TB] lock loss in run");
        repeat (LOSS) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("loss_retry", {4'd0, retry_count}, 8'd1);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("relock_retry", {4'd0, retry_count}, 8'd0);
        checkOutput("relock_ready", {7'd0, ready}, 8'd1);

`ifdef PLL_SEQ_GLITCH_FILTER_EN
        $display("[TB] glitch filter in run");
        repeat (GLITCH - 1) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("filter_short_ready", {7'd0, ready}, 8'd1);
        repeat (GLITCH) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("filter_long_retry", {4'd0, retry_count}, 8'd1);
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] restart against timeout");
        guard = 0;
        while (!(m_mode == M_WAIT && m_att == TIMEOUT - 1) && guard < 300) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 300) checkOutput("wait_timeout", 8'd0, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("restart_vs_timeout", {4'd0, retry_count}, 8'd0);

        $display("[TB] randomized PLL");
        delay = 0;
        burst = 0;
        repeat (1500) begin
            if (pll_reset) begin
                lk    = 1'b0;
                delay = $urandom_range(0, 70);
                burst = 0;
            end else if (delay > 0) begin
                delay--;
                lk = 1'b0;
            end else if (burst > 0) begin
                burst--;
                lk = 1'b0;
            end else if ($urandom_range(0, 99) < 3) begin
                burst = $urandom_range(0, 5);
                lk    = 1'b0;
            end else begin
                lk = 1'b1;
            end
            rq = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 999) == 0);
            applyStimulus(rs, lk, rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
